dither_lock_core: RTL and testbench
===================================

// Module: dither_lock_core
// PURPOSE
//  Dither-lock engine: generates a square-wave dither, demodulates an error signal synchronously, and integrates it into a lock correction.
//  Drives inhtrig, a one-cycle pulse at each dither-period start, for the dither gating block.
//  Consumes inthld from that block to freeze its integrator while the dither is gated or settling.
// PARAMETERS
//  N_B     16  width of dither, error and lock output words (signed)
//  N_HALF  64  clk cycles per dither half-period (>=2); period = 2*N_HALF
//  N_SKIP   8  samples ignored at start of each half-period for settling (0..N_HALF-1)
//  N_ACC   32  demodulator accumulator width (signed, >= N_B+log2(2*N_HALF)+1)
//  N_INT   32  integrator width (signed, N_INT >= N_B)
//  N_SHIFT  4  integrator gain: integ += demod >>> N_SHIFT (arithmetic)
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous active-low reset
//  en         in   1      lock enable; low = IDLE
//  clr        in   1      synchronous integrator/sat clear
//  inthld     in   1      integrator hold (high = freeze integ)
//  amp        in   N_B    dither amplitude, signed, must be >= 0
//  err_in     in   N_B    signed error sample, one per clk
//  dith_out   out  N_B    signed dither: +amp / -amp / 0
//  inhtrig    out  1      1-cycle pulse, coincident with first +amp cycle of each period
//  demod      out  N_ACC  signed demodulated sum of last complete period
//  demod_vld  out  1      1-cycle pulse when demod updates
//  lock_out   out  N_B    integ >>> (N_INT-N_B)
//  sat        out  1      sticky: integrator clamped since last clr/reset
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, phase=0, acc=0, integ=0; all outputs 0.
//  All outputs registered. States: IDLE, RUN.
//  IDLE: dith_out=0, inhtrig=0, demod_vld=0, phase=0, acc=0; integ holds. en=1 -> RUN.
//  RUN: phase counts 0..2*N_HALF-1, wraps to 0. First RUN cycle has phase=0.
//  In each cycle with phase p: dith_out=+amp for p<N_HALF, -amp otherwise; inhtrig=(p==0).
//  Demod: at p, s=err_in if p<N_HALF else -err_in (sign-extended to N_ACC).
//   If (p mod N_HALF)>=N_SKIP, include s; else include 0.
//   At p==0, acc <= included term (fresh start); else acc += term.
//   The p==2*N_HALF-1 term is included in that period's result.
//  Cycle after p==2*N_HALF-1: demod <= final acc, demod_vld=1 (same cycle as the next inhtrig).
//  Integrator: in the demod_vld cycle, if inthld==0, integ_next = integ + (demod >>> N_SHIFT).
//   Saturate to [-2^(N_INT-1), 2^(N_INT-1)-1]; set sat on clamp.
//   inthld==1: integ unchanged; demod still updates.
//   lock_out reflects new integ one cycle after demod_vld.
//  clr=1: integ<=0, sat<=0; takes priority over the update in the same cycle.
//  en 1->0 in RUN: next cycle IDLE, dith_out=0, partial acc discarded, no demod_vld.
//   A pending demod_vld or integ update in that cycle still completes. lock_out holds.
//  en 0->1: restarts at phase=0 with inhtrig=1; no demod_vld until a full period completes.
//  amp sampled every cycle; changes apply immediately. -amp is exact for amp >= 0.
//  rst_n low mid-operation: immediate return to reset values.
// TESTING (N_B=16, N_HALF=4, N_SKIP=1, N_ACC=32, N_INT=16, N_SHIFT=0)
//  Reset:
//   rst_n=0 -> dith_out=0, inhtrig=0, demod=0, lock_out=0, sat=0.
//  Dither:
//   en=1, amp=100 -> dith_out = 100 x4, -100 x4, repeating.
//   inhtrig=1 every 8th cycle, on first +100 cycle.
//  Demod:
//   err_in const 50 -> demod=0.
//   err_in=+10 (p<4), -10 (p>=4) -> demod=60, demod_vld every 8 cycles.
//  Hold:
//   inthld=1 for 3 periods -> lock_out const, demod_vld still pulses.
//   inthld=0 -> lock_out increases by 60 per period.
//  Saturation/clear:
//   err_in=+30000/-30000 pattern -> lock_out clamps at 32767, sat=1.
//   clr=1 -> lock_out=0, sat=0.
//  Abort:
//   en=0 at p=5 -> dith_out=0 next cycle, no demod_vld, integ unchanged.
//   en=1 -> inhtrig on first cycle.
//   rst_n pulse mid-period -> immediate reset values.

Source files
------------

// File: rtl/dither_lock_if.sv
// Bundles the lock controls, the error/dither data path and the
// dither-gating handshake (inhtrig out / inthld in) of the dither-lock engine.
interface dither_lock_if #(
   parameter int N_B   = 16,
   parameter int N_ACC = 32
);
   logic                    en;
   logic                    clr;
   logic                    inthld;
   logic signed [N_B-1:0]   amp;
   logic signed [N_B-1:0]   err_in;
   logic signed [N_B-1:0]   dith_out;
   logic                    inhtrig;
   logic signed [N_ACC-1:0] demod;
   logic                    demod_vld;
   logic signed [N_B-1:0]   lock_out;
   logic                    sat;

   modport master (
      output en, clr, inthld, amp, err_in,
      input  dith_out, inhtrig, demod, demod_vld, lock_out, sat
   );

   modport slave (
      input  en, clr, inthld, amp, err_in,
      output dith_out, inhtrig, demod, demod_vld, lock_out, sat
   );
endinterface

// File: rtl/dither_lock_core.sv
// Dither-lock engine: square-wave dither generator, synchronous demodulator
// over one full dither period, and a saturating integrator producing the
// lock correction. All outputs come straight from registers.
module dither_lock_core #(
   parameter int N_B     = 16,
   parameter int N_HALF  = 64,
   parameter int N_SKIP  = 8,
   parameter int N_ACC   = 32,
   parameter int N_INT   = 32,
   parameter int N_SHIFT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   dither_lock_if.slave  bus
);

   localparam int PW = $clog2(2 * N_HALF);
   localparam int SW = ((N_ACC > N_INT) ? N_ACC : N_INT) + 1;

   localparam logic [PW-1:0] PH_ZERO = PW'(0);
   localparam logic [PW-1:0] PH_ONE  = PW'(1);
   localparam logic [PW-1:0] PH_HALF = PW'(N_HALF);
   localparam logic [PW-1:0] PH_LAST = PW'(2 * N_HALF - 1);
   localparam logic [PW-1:0] PH_SKIP = PW'(N_SKIP);

   // Integrator limits, widened to the sum width so the clamp compare is exact.
   localparam logic signed [SW-1:0] INT_MAX_X = {{(SW-N_INT+1){1'b0}}, {(N_INT-1){1'b1}}};
   localparam logic signed [SW-1:0] INT_MIN_X = {{(SW-N_INT+1){1'b1}}, {(N_INT-1){1'b0}}};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [PW-1:0]           phase_r;
   logic [PW-1:0]           phase_nxt_s;
   logic signed [N_B-1:0]   dith_r;
   logic signed [N_B-1:0]   dith_nxt_s;
   logic                    inhtrig_r;
   logic                    inhtrig_nxt_s;
   logic                    run_active_s;
   logic                    period_end_s;

   logic [PW-1:0]           pmod_s;
   logic signed [N_ACC-1:0] err_ext_s;
   logic signed [N_ACC-1:0] term_s;
   logic signed [N_ACC-1:0] acc_sum_s;
   logic signed [N_ACC-1:0] acc_r;
   logic signed [N_ACC-1:0] demod_r;
   logic                    demod_vld_r;

   logic signed [N_ACC-1:0] dsh_s;
   logic signed [SW-1:0]    integ_ext_s;
   logic signed [SW-1:0]    dsh_ext_s;
   logic signed [SW-1:0]    sum_s;
   logic signed [N_INT-1:0] integ_r;
   logic signed [N_INT-1:0] integ_nxt_s;
   logic                    sat_r;
   logic                    sat_nxt_s;
   logic signed [N_B-1:0]   lock_r;

   // State, phase and dither output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         phase_r   <= PH_ZERO;
         dith_r    <= {N_B{1'b0}};
         inhtrig_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         phase_r   <= phase_nxt_s;
         dith_r    <= dith_nxt_s;
         inhtrig_r <= inhtrig_nxt_s;
      end
   end

   // Next state/phase; dither and trigger are precomputed for the next phase so they line up with it.
   always_comb begin
      state_nxt_s   = ST_IDLE;
      phase_nxt_s   = PH_ZERO;
      dith_nxt_s    = {N_B{1'b0}};
      inhtrig_nxt_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.en) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
            phase_nxt_s = PH_ZERO;
         end
         ST_RUN: begin
            if (bus.en) begin
               state_nxt_s = ST_RUN;
               if (phase_r == PH_LAST) begin
                  phase_nxt_s = PH_ZERO;
               end else begin
                  phase_nxt_s = phase_r + PH_ONE;
               end
            end else begin
               state_nxt_s = ST_IDLE;
               phase_nxt_s = PH_ZERO;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            phase_nxt_s = PH_ZERO;
         end
      endcase
      if (state_nxt_s == ST_RUN) begin
         if (phase_nxt_s < PH_HALF) begin
            dith_nxt_s = bus.amp;
         end else begin
            dith_nxt_s = -bus.amp;
         end
         inhtrig_nxt_s = (phase_nxt_s == PH_ZERO);
      end else begin
         dith_nxt_s    = {N_B{1'b0}};
         inhtrig_nxt_s = 1'b0;
      end
   end

   // Demodulator term: sign follows the dither half, settling samples contribute zero.
   always_comb begin
      run_active_s = (state_r == ST_RUN) && bus.en;
      period_end_s = run_active_s && (phase_r == PH_LAST);
      if (phase_r < PH_HALF) begin
         pmod_s = phase_r;
      end else begin
         pmod_s = phase_r - PH_HALF;
      end
      err_ext_s = {{(N_ACC-N_B){bus.err_in[N_B-1]}}, bus.err_in};
      if (pmod_s >= PH_SKIP) begin
         if (phase_r < PH_HALF) begin
            term_s = err_ext_s;
         end else begin
            term_s = -err_ext_s;
         end
      end else begin
         term_s = {N_ACC{1'b0}};
      end
      if (phase_r == PH_ZERO) begin
         acc_sum_s = term_s;
      end else begin
         acc_sum_s = acc_r + term_s;
      end
   end

   // Period accumulator; cleared whenever the engine is not running so an abort drops the partial sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r <= {N_ACC{1'b0}};
      end else if (run_active_s) begin
         acc_r <= acc_sum_s;
      end else begin
         acc_r <= {N_ACC{1'b0}};
      end
   end

   // Publish the completed period sum together with a one-cycle valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         demod_r     <= {N_ACC{1'b0}};
         demod_vld_r <= 1'b0;
      end else if (period_end_s) begin
         demod_r     <= acc_sum_s;
         demod_vld_r <= 1'b1;
      end else begin
         demod_vld_r <= 1'b0;
      end
   end

   // Integrator next value: clear wins, otherwise add the scaled demod on valid unless held, with clamping.
   always_comb begin
      dsh_s       = demod_r >>> N_SHIFT;
      integ_ext_s = {{(SW-N_INT){integ_r[N_INT-1]}}, integ_r};
      dsh_ext_s   = {{(SW-N_ACC){dsh_s[N_ACC-1]}}, dsh_s};
      sum_s       = integ_ext_s + dsh_ext_s;
      integ_nxt_s = integ_r;
      sat_nxt_s   = sat_r;
      if (bus.clr) begin
         integ_nxt_s = {N_INT{1'b0}};
         sat_nxt_s   = 1'b0;
      end else if (demod_vld_r && !bus.inthld) begin
         if (sum_s > INT_MAX_X) begin
            integ_nxt_s = INT_MAX_X[N_INT-1:0];
            sat_nxt_s   = 1'b1;
         end else if (sum_s < INT_MIN_X) begin
            integ_nxt_s = INT_MIN_X[N_INT-1:0];
            sat_nxt_s   = 1'b1;
         end else begin
            integ_nxt_s = sum_s[N_INT-1:0];
         end
      end else begin
         integ_nxt_s = integ_r;
         sat_nxt_s   = sat_r;
      end
   end

   // Integrator, sticky saturation flag and the lock output taken from the integrator's top bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         integ_r <= {N_INT{1'b0}};
         sat_r   <= 1'b0;
         lock_r  <= {N_B{1'b0}};
      end else begin
         integ_r <= integ_nxt_s;
         sat_r   <= sat_nxt_s;
         lock_r  <= integ_nxt_s[N_INT-1 -: N_B];
      end
   end

   assign bus.dith_out  = dith_r;
   assign bus.inhtrig   = inhtrig_r;
   assign bus.demod     = demod_r;
   assign bus.demod_vld = demod_vld_r;
   assign bus.lock_out  = lock_r;
   assign bus.sat       = sat_r;

endmodule

// File: tb/tb_dither_lock_core.sv
// Directed bench for dither_lock_core with N_HALF=4, N_SKIP=1, N_INT=16, N_SHIFT=0.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_dither_lock_core;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;
   int   ph;
   int   have_prev;
   int   last_exp;
   int   exp_lock;
   int   exp_sat;

   dither_lock_if #(.N_B(16), .N_ACC(32)) bus ();

   dither_lock_core #(
      .N_B(16), .N_HALF(4), .N_SKIP(1), .N_ACC(32), .N_INT(16), .N_SHIFT(0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One RUN cycle: check outputs for phase ph, drive the error sample, update the integrator model.
   task automatic cyc(input logic signed [15:0] ep, input logic signed [15:0] em,
                      input int exp_dm);
      logic vld_exp;
      int   s;
      vld_exp = (ph == 0) && (have_prev != 0);
      chk_val("dith_out", bus.dith_out, (ph < 4) ? 100 : -100);
      chk_val("inhtrig", bus.inhtrig, (ph == 0));
      chk_val("demod_vld", bus.demod_vld, vld_exp);
      if (vld_exp) chk_val("demod", bus.demod, last_exp);
      chk_val("lock_out", bus.lock_out, exp_lock);
      chk_val("sat", bus.sat, exp_sat);
      bus.err_in = (ph < 4) ? ep : em;
      if (bus.clr) begin
         exp_lock = 0;
         exp_sat  = 0;
      end else if (vld_exp && !bus.inthld) begin
         s = exp_lock + last_exp;
         if (s > 32767) begin
            exp_lock = 32767;
            exp_sat  = 1;
         end else if (s < -32768) begin
            exp_lock = -32768;
            exp_sat  = 1;
         end else begin
            exp_lock = s;
         end
      end
      if (ph == 7) begin
         last_exp  = exp_dm;
         have_prev = 1;
      end
      tick();
      ph = (ph + 1) % 8;
   endtask

   task automatic run_period(input logic signed [15:0] ep, input logic signed [15:0] em,
                             input int exp_dm, input logic hold, input logic clr0);
      for (int i = 0; i < 8; i++) begin
         bus.inthld = hold;
         bus.clr    = (i == 0) ? clr0 : 1'b0;
         cyc(ep, em, exp_dm);
      end
      bus.clr = 1'b0;
   endtask

   initial begin
      clk = 1'b0;
      rst_n = 1'b0;
      n_cmp = 0;
      n_bad = 0;
      ph = 0;
      have_prev = 0;
      last_exp = 0;
      exp_lock = 0;
      exp_sat = 0;
      bus.en = 1'b0;
      bus.clr = 1'b0;
      bus.inthld = 1'b0;
      bus.amp = 16'sd100;
      bus.err_in = 16'sd0;

      tick();
      tick();
      chk_val("rst_dith", bus.dith_out, 0);
      chk_val("rst_inhtrig", bus.inhtrig, 0);
      chk_val("rst_demod", bus.demod, 0);
      chk_val("rst_lock", bus.lock_out, 0);
      chk_val("rst_sat", bus.sat, 0);

      rst_n = 1'b1;
      tick();
      bus.en = 1'b1;
      tick();

      run_period(16'sd50, 16'sd50, 0, 1'b0, 1'b0);
      run_period(16'sd50, 16'sd50, 0, 1'b0, 1'b0);
      run_period(16'sd10, -16'sd10, 60, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) run_period(16'sd10, -16'sd10, 60, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) run_period(16'sd10, -16'sd10, 60, 1'b0, 1'b0);
      chk_val("lock_after_hold", bus.lock_out, 180);

      for (int k = 0; k < 3; k++) run_period(16'sd30000, -16'sd30000, 180000, 1'b0, 1'b0);
      chk_val("lock_clamped", bus.lock_out, 32767);
      chk_val("sat_set", bus.sat, 1);

      run_period(16'sd10, -16'sd10, 60, 1'b0, 1'b1);
      chk_val("lock_cleared", bus.lock_out, 0);
      chk_val("sat_cleared", bus.sat, 0);

      run_period(16'sd10, -16'sd10, 60, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) cyc(16'sd10, -16'sd10, 60);

      // Abort at phase 5.
      chk_val("abort_ph5_dith", bus.dith_out, -100);
      bus.en = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         chk_val("idle_dith", bus.dith_out, 0);
         chk_val("idle_inhtrig", bus.inhtrig, 0);
         chk_val("idle_vld", bus.demod_vld, 0);
         chk_val("idle_lock", bus.lock_out, 120);
         tick();
      end

      bus.en = 1'b1;
      tick();
      ph = 0;
      have_prev = 0;
      chk_val("restart_inhtrig", bus.inhtrig, 1);
      run_period(16'sd10, -16'sd10, 60, 1'b0, 1'b0);
      run_period(16'sd10, -16'sd10, 60, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) cyc(16'sd10, -16'sd10, 60);

      // Asynchronous reset mid-period.
      rst_n = 1'b0;
      #1;
      chk_val("arst_dith", bus.dith_out, 0);
      chk_val("arst_inhtrig", bus.inhtrig, 0);
      chk_val("arst_demod", bus.demod, 0);
      chk_val("arst_vld", bus.demod_vld, 0);
      chk_val("arst_lock", bus.lock_out, 0);
      chk_val("arst_sat", bus.sat, 0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
